exe_iter_divider: RTL and testbench

- Parametrised iterative restoring divider used by the execute stage for div.w / mod.w / div.wu / mod.wu.
- Replaces the fixed 32-bit radix-4 core.
- Adds the following over the fixed core:
  - configurable operand width;
  - working synchronous flush input;
  - defined divide-by-zero and overflow results;
  - optional early termination for small dividends.
- Interfaces to the stage through start (valid/ready) and finish (valid/ready) handshakes.

---
 rtl/exe_iter_divider.sv | 178 +++++++++++++++++
 tb/tb_exe_iter_divider.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_iter_divider.sv
// Iterative restoring divider for div.w/mod.w/div.wu/mod.wu; one quotient bit per cycle.
// Latency: accept to finish_valid_o is WIDTH+3 cycles, 3 on zero divisor, (WIDTH-lz)+3 with EARLY_OUT.
// Backpressure: holds results in DONE until finish_ready_i; start_ready_o only in IDLE; flush_i cancels anywhere.
module exe_iter_divider #(
  parameter int WIDTH     = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic             signed_op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             finish_valid_o,
  input  logic             finish_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             divisor_is_zero_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, PREP, ITER, POST, DONE} state_t;

  state_t           state_q, state_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] abs_b_q, abs_b_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out the top, quotient bits shift in below
  logic [WIDTH-1:0] rem_q, rem_d;   // always < abs divisor, so WIDTH bits suffice between steps
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dz_out_q, dz_out_d;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [CW-1:0]    lz;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;

  // Magnitudes of the latched operands; -MIN wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign abs_a = neg_a_q ? -dvd_q : dvd_q;
  assign abs_b = neg_b_q ? -dvs_q : dvs_q;

  // One restoring step: WIDTH+1 bit partial remainder trial-compared against the divisor.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, abs_b_q};
  assign rem_diff  = rem_shift[WIDTH-1:0] - abs_b_q;

  // Leading-zero count of the absolute dividend (WIDTH when it is zero).
  always_comb begin
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (abs_a[i]) lz = CW'(WIDTH - 1 - i);
    end
  end

  assign start_ready_o     = (state_q == IDLE) & ~flush_i;
  assign finish_valid_o    = (state_q == DONE) & ~flush_i;
  assign busy_o            = (state_q != IDLE);
  assign quotient_o        = q_out_q;
  assign remainder_o       = r_out_q;
  assign divisor_is_zero_o = dz_out_q;

  // Next-state and datapath: every register holds unless its state updates it; flush overrides the state.
  always_comb begin
    state_d  = state_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    abs_b_d  = abs_b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    q_out_d  = q_out_q;
    r_out_d  = r_out_q;
    dz_out_d = dz_out_q;
    case (state_q)
      IDLE: begin
        if (start_valid_i && start_ready_o) begin
          dvd_d   = dividend_i;
          dvs_d   = divisor_i;
          neg_a_d = signed_op_i & dividend_i[WIDTH-1];
          neg_b_d = signed_op_i & divisor_i[WIDTH-1];
          state_d = PREP;
        end
      end
      PREP: begin
        abs_b_d = abs_b;
        rem_d   = '0;
        zero_d  = 1'b0;
        if (abs_b == '0) begin
          zero_d  = 1'b1;
          state_d = POST;
        end else if (EARLY_OUT != 0) begin
          // Leading zeros of the dividend would only produce zero quotient bits; skip them.
          cnt_d   = CW'(WIDTH) - lz;
          quo_d   = abs_a << lz;
          state_d = (abs_a == '0) ? POST : ITER;
        end else begin
          cnt_d   = CW'(WIDTH);
          quo_d   = abs_a;
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = POST;
      end
      POST: begin
        // Results only land when DONE is actually entered, so a flush here leaves them untouched.
        if (!flush_i) begin
          if (zero_q) begin
            q_out_d  = '1;
            r_out_d  = dvd_q;
            dz_out_d = 1'b1;
          end else begin
            q_out_d  = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
            r_out_d  = neg_a_q ? -rem_q : rem_q;
            dz_out_d = 1'b0;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        if (finish_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      abs_b_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      q_out_q  <= '0;
      r_out_q  <= '0;
      dz_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      abs_b_q  <= abs_b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      q_out_q  <= q_out_d;
      r_out_q  <= r_out_d;
      dz_out_q <= dz_out_d;
    end
  end

endmodule

// File: tb/tb_exe_iter_divider.sv
// Bench for exe_iter_divider: a 32-bit full-iteration instance and an 8-bit early-out instance.
// Directed vectors from a table, hand-written flush/backpressure/reset sequences, then random ops
// compared against an arithmetic reference model.
module tb_exe_iter_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  // Instance A: WIDTH=32, EARLY_OUT=0
  logic        a_flush, a_sv, a_sr, a_sign, a_fv, a_fr, a_dz, a_busy;
  logic [31:0] a_dvd, a_dvs, a_q, a_r;
  // Instance B: WIDTH=8, EARLY_OUT=1
  logic        b_flush, b_sv, b_sr, b_sign, b_fv, b_fr, b_dz, b_busy;
  logic [7:0]  b_dvd, b_dvs, b_q, b_r;

  exe_iter_divider #(.WIDTH(32), .EARLY_OUT(0)) u_a (
    .clk(clk), .resetn(resetn), .flush_i(a_flush),
    .start_valid_i(a_sv), .start_ready_o(a_sr), .signed_op_i(a_sign),
    .dividend_i(a_dvd), .divisor_i(a_dvs),
    .finish_valid_o(a_fv), .finish_ready_i(a_fr),
    .quotient_o(a_q), .remainder_o(a_r), .divisor_is_zero_o(a_dz), .busy_o(a_busy)
  );

  exe_iter_divider #(.WIDTH(8), .EARLY_OUT(1)) u_b (
    .clk(clk), .resetn(resetn), .flush_i(b_flush),
    .start_valid_i(b_sv), .start_ready_o(b_sr), .signed_op_i(b_sign),
    .dividend_i(b_dvd), .divisor_i(b_dvs),
    .finish_valid_o(b_fv), .finish_ready_i(b_fr),
    .quotient_o(b_q), .remainder_o(b_r), .divisor_is_zero_o(b_dz), .busy_o(b_busy)
  );

  // Selected-instance view used by the generic operation task.
  logic        sel;
  logic        s_sr, s_fv, s_dz, s_busy;
  logic [31:0] s_q, s_r;
  always_comb begin
    if (sel) begin
      s_sr = b_sr; s_fv = b_fv; s_dz = b_dz; s_busy = b_busy;
      s_q = {24'd0, b_q}; s_r = {24'd0, b_r};
    end else begin
      s_sr = a_sr; s_fv = a_fv; s_dz = a_dz; s_busy = a_busy;
      s_q = a_q; s_r = a_r;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input bit v, input bit s, input logic [31:0] a, input logic [31:0] b);
    if (sel) begin b_sv = v; b_sign = s; b_dvd = a[7:0]; b_dvs = b[7:0]; end
    else     begin a_sv = v; a_sign = s; a_dvd = a;      a_dvs = b;      end
  endtask

  task automatic set_fr(input bit v);
    if (sel) b_fr = v; else a_fr = v;
  endtask

  task automatic set_flush(input bit v);
    if (sel) b_flush = v; else a_flush = v;
  endtask

  // Sign-interpret a w-bit value held in the low bits of v.
  function automatic longint sx(input logic [31:0] v, input int w, input bit s);
    longint m = (longint'(1) << w) - 1;
    longint x = longint'(v) & m;
    if (s && (((x >> (w - 1)) & 1) == 1)) x = x - (longint'(1) << w);
    return x;
  endfunction

  // Reference: plain integer division/modulo, truncated to w bits, plus the expected cycle count.
  function automatic void ref_div(input int w, input bit eo, input bit s,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output bit dz, output int lat);
    longint m  = (longint'(1) << w) - 1;
    longint sa = sx(a, w, s);
    longint sb = sx(b, w, s);
    longint mag;
    int     n;
    if (sb == 0) begin
      q = 32'(m); r = 32'(longint'(a) & m); dz = 1'b1; lat = 3;
    end else begin
      q  = 32'((sa / sb) & m);
      r  = 32'((sa % sb) & m);
      dz = 1'b0;
      if (eo) begin
        mag = (sa < 0) ? -sa : sa;
        n = 0;
        while (mag != 0) begin n++; mag = mag >> 1; end
        lat = n + 3;
      end else begin
        lat = w + 3;
      end
    end
  endfunction

  // One complete operation: accept, count cycles to finish_valid_o, check results, optional hold, release.
  task automatic do_op(input string name, input bit which, input bit s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input bit edz,
                       input int elat, input int hold);
    int          lat;
    bit          busy_ok;
    bit          stable;
    logic [31:0] hq, hr;
    sel = which;
    @(negedge clk);
    set_fr(hold == 0);
    set_start(1'b1, s, a, b);
    for (int k = 0; k < 100 && !s_sr; k++) @(negedge clk);
    @(negedge clk);
    set_start(1'b0, 1'b0, 32'd0, 32'd0);
    lat = 1;
    busy_ok = 1'b1;
    while (!s_fv && lat < 200) begin
      if (!s_busy || s_sr) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(elat));
    check({name, " quotient"}, {32'd0, s_q}, {32'd0, eq});
    check({name, " remainder"}, {32'd0, s_r}, {32'd0, er});
    check({name, " div_zero"}, {63'd0, s_dz}, {63'd0, edz});
    check({name, " busy/not-ready while working"}, {63'd0, busy_ok}, 64'd1);
    if (hold > 0) begin
      hq = s_q; hr = s_r; stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!s_fv || s_sr || s_q !== hq || s_r !== hr) stable = 1'b0;
      end
      check({name, " held in DONE"}, {63'd0, stable}, 64'd1);
      set_fr(1'b1);
    end
    @(negedge clk);
    check({name, " back to idle {fv,sr,busy}"}, {61'd0, s_fv, s_sr, s_busy}, 64'b010);
  endtask

  typedef struct {
    string       name;
    bit          which;
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          dz;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"u32 100/7",        0, 0, 32'd100,        32'd7,          32'd14,         32'd2,          0, 35, 0};
    vecs[1]  = '{"s32 -7/2",         0, 1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   0, 35, 0};
    vecs[2]  = '{"s32 7/-2",         0, 1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          0, 35, 0};
    vecs[3]  = '{"u32 FFFFFFF9/2",   0, 0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          0, 35, 0};
    vecs[4]  = '{"u32 div by zero",  0, 0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1,  3, 0};
    vecs[5]  = '{"s32 MIN/-1",       0, 1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          0, 35, 0};
    vecs[6]  = '{"u32 1000/10 hold", 0, 0, 32'd1000,       32'd10,         32'd100,        32'd0,          0, 35, 5};
    vecs[7]  = '{"u8 5/3 early",     1, 0, 32'd5,          32'd3,          32'd1,          32'd2,          0,  6, 0};
    vecs[8]  = '{"u8 0/5 early",     1, 0, 32'd0,          32'd5,          32'd0,          32'd0,          0,  3, 0};
    vecs[9]  = '{"s8 MIN/-1",        1, 1, 32'h80,         32'hFF,         32'h80,         32'h00,         0, 11, 0};
    vecs[10] = '{"s8 -7/2 early",    1, 1, 32'hF9,         32'h02,         32'hFD,         32'hFF,         0,  6, 0};
    vecs[11] = '{"s8 div by zero",   1, 1, 32'h85,         32'h00,         32'hFF,         32'h85,         1,  3, 2};

    sel = 1'b0;
    a_flush = 0; a_sv = 0; a_sign = 0; a_dvd = 0; a_dvs = 0; a_fr = 1;
    b_flush = 0; b_sv = 0; b_sign = 0; b_dvd = 0; b_dvs = 0; b_fr = 1;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("reset A {sr,fv,busy,dz}", {60'd0, a_sr, a_fv, a_busy, a_dz}, 64'b1000);
    check("reset A {q,r}", {a_q, a_r}, 64'd0);
    check("reset B {sr,fv,busy,dz}", {60'd0, b_sr, b_fv, b_busy, b_dz}, 64'b1000);
    check("reset B {q,r}", {32'd0, 8'd0, b_q, 8'd0, b_r}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].which, vecs[i].s, vecs[i].a, vecs[i].b,
            vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, vecs[i].hold);

    // Flush during iteration 10, then a clean follow-up divide.
    sel = 1'b0;
    @(negedge clk);
    set_fr(1'b1);
    set_start(1'b1, 1'b0, 32'd100, 32'd7);
    @(negedge clk);
    set_start(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    set_flush(1'b1);
    #1;
    check("flush mid-iter {fv,sr}", {62'd0, s_fv, s_sr}, 64'b00);
    @(negedge clk);
    set_flush(1'b0);
    #1;
    check("after flush {fv,sr,busy}", {61'd0, s_fv, s_sr, s_busy}, 64'b010);
    do_op("u32 9/3 after flush", 0, 0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 35, 0);

    // Flush together with start: request must be refused.
    @(negedge clk);
    set_flush(1'b1);
    set_start(1'b1, 1'b0, 32'd50, 32'd5);
    #1;
    check("flush+start ready", {63'd0, s_sr}, 64'd0);
    @(negedge clk);
    set_flush(1'b0);
    set_start(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("flush+start not accepted busy", {63'd0, s_busy}, 64'd0);

    // Flush while holding a result in DONE: valid drops in the same cycle.
    @(negedge clk);
    set_fr(1'b0);
    set_start(1'b1, 1'b0, 32'd20, 32'd4);
    @(negedge clk);
    set_start(1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 100 && !s_fv; k++) @(negedge clk);
    check("done before flush fv", {63'd0, s_fv}, 64'd1);
    check("done before flush q", {32'd0, s_q}, 64'd5);
    set_flush(1'b1);
    #1;
    check("flush in DONE fv", {63'd0, s_fv}, 64'd0);
    @(negedge clk);
    set_flush(1'b0);
    set_fr(1'b1);
    #1;
    check("after DONE flush {fv,sr,busy}", {61'd0, s_fv, s_sr, s_busy}, 64'b010);

    // Asynchronous reset in the middle of an 8-bit iteration.
    do_op("u8 200/7", 1, 0, 32'd200, 32'd7, 32'd28, 32'd4, 0, 11, 0);
    sel = 1'b1;
    @(negedge clk);
    set_start(1'b1, 1'b0, 32'd200, 32'd3);
    @(negedge clk);
    set_start(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async reset B {sr,fv,busy,dz}", {60'd0, b_sr, b_fv, b_busy, b_dz}, 64'b1000);
    check("async reset B {q,r}", {48'd0, b_q, b_r}, 64'd0);
    check("async reset A {q,r}", {a_q, a_r}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Random operations against the reference model.
    for (int n = 0; n < 80; n++) begin
      bit          w8, s;
      logic [31:0] a, b, eq, er;
      bit          edz;
      int          elat, mode;
      w8   = 1'($urandom_range(0, 1));
      s    = 1'($urandom_range(0, 1));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 5);
      case (mode)
        0: b = 32'd0;
        1: a = 32'($urandom_range(0, 20));
        2: b = 32'($urandom_range(1, 9));
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      if (w8) begin a = a & 32'hFF; b = b & 32'hFF; end
      ref_div(w8 ? 8 : 32, w8, s, a, b, eq, er, edz, elat);
      do_op($sformatf("rand%0d", n), w8, s, a, b, eq, er, edz, elat, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
